// File: rtl/pq_pkg.sv
// ============================================================================
// Module : pq_pkg
// Brief  : Shared item type, sorter state encoding and priority-order helper
//          for the priority-queue family.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pq_pkg;

   localparam int KEY_W = 8;
   localparam int VAL_W = 8;

   typedef struct packed {
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] val;
   } kv_t;

   typedef enum logic {SRT_LOAD, SRT_DRAIN} srt_state_t;

   // Max-first ordering; equal keys impose no order between items.
   function automatic logic kv_before(kv_t a, kv_t b);
      return (a.key > b.key);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pq_if.sv
// ============================================================================
// Module : pq_if
// Brief  : Client/device connection to a priority queue (enq/deq + status).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pq_if;
   import pq_pkg::*;

   kv_t  kvi;
   logic enq;
   logic deq;
   logic full;
   logic busy;
   logic empty;
   kv_t  kvo;

   modport client (output kvi, enq, deq, input full, busy, empty, kvo);
   modport device (input kvi, enq, deq, output full, busy, empty, kvo);
endinterface

`default_nettype wire

// File: rtl/pq_order_chk.sv
// ============================================================================
// Module : pq_order_chk
// Brief  : Remembers the previously emitted item of a batch and raises a
//          sticky error when a later item should have left the queue first.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pq_order_chk
   import pq_pkg::*;
(
   input  wire  clk,
   input  wire  rst,
   input  wire  i_fire,
   input  kv_t  i_kv,
   input  wire  i_last,
   output logic o_err
);

   kv_t  r_prev;
   logic r_have_prev;
   logic r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev      <= '0;
         r_have_prev <= 1'b0;
         r_err       <= 1'b0;
      end else if (i_fire) begin
         if (r_have_prev && kv_before(i_kv, r_prev)) begin
            r_err <= 1'b1;
         end
         if (i_last) begin
            r_prev      <= '0;
            r_have_prev <= 1'b0;
         end else begin
            r_prev      <= i_kv;
            r_have_prev <= 1'b1;
         end
      end
   end

   assign o_err = r_err;

endmodule

`default_nettype wire

// File: rtl/pq_batch_sorter.sv
// ============================================================================
// Module : pq_batch_sorter
// Brief  : Loads a batch into an attached priority queue, then drains it in
//          priority order. Optional output-order checker: PQ_SORT_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pq_batch_sorter
   import pq_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int CNTW  = $clog2(DEPTH + 1)
) (
   input  wire             clk,
   input  wire             rst,
   input  kv_t             in_kv,
   input  wire             in_valid,
   input  wire             in_last,
   output logic            in_ready,
   output kv_t             out_kv,
   output logic            out_valid,
   output logic            out_last,
   input  wire             out_ready,
   pq_if.client            pq,
   output logic [CNTW-1:0] batch_cnt,
   output logic            overflow,
   output logic            order_err
);

   localparam logic [CNTW-1:0] C_DEPTH = CNTW'(DEPTH);
   localparam logic [CNTW-1:0] C_ONE   = CNTW'(1);

   srt_state_t      r_state;
   srt_state_t      w_state_nxt;
   logic [CNTW-1:0] r_cnt;
   logic [CNTW-1:0] w_cnt_nxt;
   logic            r_guard;
   logic            r_overflow;
   logic            w_ovf_nxt;
   logic            w_pq_idle;
   logic            w_enq;
   logic            w_deq;
   kv_t             w_kvi;

   // One op per two cycles: the PQ needs a cycle to settle after every op.
   assign w_pq_idle = !r_guard && !pq.busy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= SRT_LOAD;
         r_cnt      <= '0;
         r_guard    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_guard    <= w_enq || w_deq;
         r_overflow <= w_ovf_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ovf_nxt   = r_overflow;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_last    = 1'b0;
      out_kv      = '0;
      w_kvi       = '0;
      w_enq       = 1'b0;
      w_deq       = 1'b0;
      // Outputs are forced quiet for the whole reset pulse, not just after it.
      if (!rst) begin
         case (r_state)
            SRT_LOAD: begin
               in_ready = w_pq_idle && !pq.full && (r_cnt < C_DEPTH);
               w_kvi    = in_kv;
               w_enq    = in_valid && in_ready;
               if (w_enq) begin
                  w_cnt_nxt = r_cnt + C_ONE;
                  if (in_last) begin
                     w_state_nxt = SRT_DRAIN;
                  end else if (w_cnt_nxt == C_DEPTH) begin
                     w_state_nxt = SRT_DRAIN;
                     w_ovf_nxt   = 1'b1;
                  end
               end
            end
            SRT_DRAIN: begin
               out_valid = w_pq_idle && !pq.empty;
               out_kv    = pq.kvo;
               out_last  = out_valid && (r_cnt == C_ONE);
               w_deq     = out_valid && out_ready;
               if (w_deq) begin
                  if (r_cnt == C_ONE) begin
                     w_state_nxt = SRT_LOAD;
                     w_cnt_nxt   = '0;
                  end else begin
                     w_cnt_nxt = r_cnt - C_ONE;
                  end
               end
            end
            default: w_state_nxt = SRT_LOAD;
         endcase
      end
   end

   assign pq.kvi    = w_kvi;
   assign pq.enq    = w_enq;
   assign pq.deq    = w_deq;
   assign batch_cnt = r_cnt;
   assign overflow  = r_overflow;

`ifdef PQ_SORT_CHECK_EN
   pq_order_chk u_order_chk (
      .clk    (clk),
      .rst    (rst),
      .i_fire (w_deq),
      .i_kv   (out_kv),
      .i_last (out_last),
      .o_err  (order_err)
   );
`else
   assign order_err = 1'b0;
`endif

endmodule

`default_nettype wire
